idx_alloc: RTL and testbench
============================

# idx_alloc

Index allocator that owns a pool of ENTRY slots, finds the lowest-numbered free slot by priority encoding, and presents it as a registered, prefetched index on a valid/ready output port. Consumers are rename, tag and buffer-slot logic. Released indices come back through a single release port. The block sits directly downstream of a priority encoder stage: it wraps the active-high lowest-index search around a busy bitmap and turns the combinational result into a sequential allocation service.

## Interface
- ENTRY, 32, number of allocatable slots; any value >= 2, not necessarily a power of two
- OUT, $clog2(ENTRY), index width; constant, do not override
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alloc_valid  out  1  out_idx holds a reserved free slot
- alloc_ready  in  1  consumer takes out_idx this cycle when alloc_valid=1
- out_idx  out  OUT  reserved slot index
- rel_valid  in  1  return a slot to the pool
- rel_idx  in  OUT  slot being returned
- free_cnt  out  OUT+1  number of zero bits in the busy bitmap
- err  out  1  sticky illegal-release flag

## Operation
- State:
  - busy[ENTRY-1:0]; 1 = slot reserved, either held in the output register or handed out.
  - Output register: alloc_valid, out_idx.
  - err.
- Reset values: busy=0, alloc_valid=0, out_idx=0, err=0, free_cnt=ENTRY.
- Pop: alloc_valid & alloc_ready. The slot leaves the output register and stays busy (now owned by the consumer).
- Refill:
  - Condition: the output register is empty, or being popped this cycle, and at least one busy bit is 0.
  - Action: next edge loads out_idx with the lowest index i where busy[i]=0, sets busy[i], and sets alloc_valid=1.
  - If no zero bit exists, the next edge clears alloc_valid (on pop) or leaves it 0.
- Search input: the search uses the registered busy bitmap only. A release in the same cycle does not take part in that cycle's search; there is no bypass.
- Legal release: rel_valid with rel_idx < ENTRY, busy[rel_idx]=1, and not (alloc_valid & rel_idx==out_idx). The next edge clears busy[rel_idx].
- Illegal release: any other rel_valid. The cycle changes no busy bits and sets err; err holds until reset.
- Release of the slot popped in the same cycle: treated as illegal (the slot was not yet owned by the consumer at cycle start). Sets err.
- Same slot released and refilled in one cycle: impossible, because the refill target has busy=0 and the release target has busy=1.
- free_cnt: registered. Equals ENTRY minus the popcount of busy after the edge. Per edge it changes by refill (-1) + legal release (+1).
- alloc_valid does not depend combinationally on alloc_ready. out_idx changes only on a refill edge.

## Timing
- First reservation: reset deasserted on edge 0 → alloc_valid=1, out_idx=0 after edge 1.
- Back-to-back: alloc_ready held high gives one new index per cycle (0,1,2,…) with no bubbles while slots remain.
- Release latency: released at edge t → busy bit clear after edge t → earliest possible appearance on out_idx is after edge t+1.
- Full pool: the last slot is held in the register. After it is popped, alloc_valid=0 the next cycle and stays 0 until a legal release; it reasserts 2 edges after the release.
- Reset mid-operation: overrides everything in the same edge. All state returns to reset values, previously handed-out slots are forgotten, and err clears.

## Test plan
- Reset then idle, ENTRY=8, alloc_ready=0: alloc_valid=1, out_idx=0 after edge 1; free_cnt=7; out_idx stays 0 for 10 cycles.
- Drain, ENTRY=8, alloc_ready=1 continuously: out_idx 0..7 on consecutive cycles; alloc_valid=0 from the cycle after index 7 is popped; free_cnt reaches 0; err=0.
- Refill after full: from the drained state, release idx 5 at edge t → free_cnt=1 after t; alloc_valid=1, out_idx=5 after t+1; free_cnt=0.
- Lowest-first with holes: hand out 0..5, release 4 then 1 → subsequent pops return 6, 1, 4, 7 in that order.
- Illegal releases, each setting err, with busy and free_cnt unchanged:
  - idx 3 never allocated
  - idx equal to the currently held out_idx
  - idx 6 with ENTRY=6
  - err stays 1 after further legal traffic.
- Reset mid-operation: with 5 slots outstanding and err=1, assert reset for one edge → alloc_valid=0, free_cnt=ENTRY, err=0; next edge out_idx=0, alloc_valid=1.

Source files
------------

// File: rtl/idx_alloc_if.sv
// Allocation/release bus for idx_alloc: prefetched index output, release input and pool status.
interface idx_alloc_if #(
    parameter int ENTRY = 32
);
    localparam int OUT = $clog2(ENTRY);

    logic           alloc_valid;
    logic           alloc_ready;
    logic [OUT-1:0] out_idx;
    logic           rel_valid;
    logic [OUT-1:0] rel_idx;
    logic [OUT:0]   free_cnt;
    logic           err;

    modport master (
        output alloc_valid,
        output out_idx,
        output free_cnt,
        output err,
        input  alloc_ready,
        input  rel_valid,
        input  rel_idx
    );

    modport slave (
        input  alloc_valid,
        input  out_idx,
        input  free_cnt,
        input  err,
        output alloc_ready,
        output rel_valid,
        output rel_idx
    );
endinterface

// File: rtl/idx_alloc.sv
// Lowest-free-slot allocator over a busy bitmap with a registered, prefetched output index
// and a single release port; illegal releases are dropped and latch a sticky error.
module idx_alloc #(
    parameter int ENTRY = 32
) (
    input  logic          clk,
    input  logic          reset,
    idx_alloc_if.master   bus
);
    localparam int OUT = $clog2(ENTRY);
    localparam logic [OUT:0] FULL_CNT = (OUT+1)'(ENTRY);
    localparam logic [OUT:0] ONE_CNT  = (OUT+1)'(1);

    logic [ENTRY-1:0] busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [OUT-1:0]   idx_q, idx_d;
    logic [OUT:0]     free_q, free_d;
    logic             err_q, err_d;

    logic [ENTRY-1:0] fill_hit;
    logic [ENTRY-1:0] rel_hit;
    logic [OUT-1:0]   search_idx;
    logic             search_found;
    logic             pop;
    logic             refill;
    logic             rel_ok;

    // Lowest-index zero search over the registered bitmap only (no release bypass).
    always_comb begin
        search_found = 1'b0;
        search_idx   = '0;
        fill_hit     = '0;
        for (int unsigned i = 0; i < ENTRY; i++) begin
            if (!search_found && !busy_q[i]) begin
                search_found = 1'b1;
                search_idx   = OUT'(i);
                fill_hit[i]  = 1'b1;
            end
        end
    end

    // Out-of-range indices decode to an all-zero mask and therefore never look busy.
    always_comb begin
        rel_hit = '0;
        for (int unsigned i = 0; i < ENTRY; i++) begin
            rel_hit[i] = (bus.rel_idx == OUT'(i));
        end
    end

    assign pop    = valid_q && bus.alloc_ready;
    assign refill = (!valid_q || pop) && search_found;
    assign rel_ok = bus.rel_valid
                 && (|(rel_hit & busy_q))
                 && !(valid_q && (bus.rel_idx == idx_q));

    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        free_d  = free_q;
        err_d   = err_q;

        if (refill) begin
            busy_d  = busy_d | fill_hit;
            valid_d = 1'b1;
            idx_d   = search_idx;
        end else if (pop) begin
            valid_d = 1'b0;
        end

        if (rel_ok) begin
            busy_d = busy_d & ~rel_hit;
        end

        if (refill && !rel_ok) begin
            free_d = free_q - ONE_CNT;
        end else if (rel_ok && !refill) begin
            free_d = free_q + ONE_CNT;
        end

        if (bus.rel_valid && !rel_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            free_q  <= FULL_CNT;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            free_q  <= free_d;
            err_q   <= err_d;
        end
    end

    assign bus.alloc_valid = valid_q;
    assign bus.out_idx     = idx_q;
    assign bus.free_cnt    = free_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_idx_alloc.sv
// Directed vector table, hand-written corner sequences and a randomized run against an
// ownership-set model for idx_alloc (ENTRY=8 main instance, ENTRY=6 for range checks).
module tb_idx_alloc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8;
    logic rst6;

    idx_alloc_if #(.ENTRY(8)) bus8 ();
    idx_alloc_if #(.ENTRY(6)) bus6 ();

    idx_alloc #(.ENTRY(8)) u_dut8 (.clk(clk), .reset(rst8), .bus(bus8.master));
    idx_alloc #(.ENTRY(6)) u_dut6 (.clk(clk), .reset(rst6), .bus(bus6.master));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string tag;
        bit    rst;
        bit    rdy;
        bit    rv;
        int    ri;
        bit    ev;
        int    ei;
        int    ef;
        bit    ee;
    } vec_t;

    vec_t tbl[$];

    // Reference model: slots owned by the consumer, the slot held in the output register.
    bit m_owned[8];
    int m_held;
    int m_last;
    bit m_err;

    function automatic void add(string tag, bit rst, bit rdy, bit rv, int ri,
                                bit ev, int ei, int ef, bit ee);
        vec_t v;
        v.tag = tag; v.rst = rst; v.rdy = rdy; v.rv = rv; v.ri = ri;
        v.ev = ev; v.ei = ei; v.ef = ef; v.ee = ee;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input bit rst, input bit rdy, input bit rv, input int ri);
        rst8              = rst;
        bus8.alloc_ready  = rdy;
        bus8.rel_valid    = rv;
        bus8.rel_idx      = 3'(ri);
    endtask

    task automatic check8(input string tag, input bit ev, input int ei, input int ef, input bit ee);
        chk({tag, ".valid"}, int'(bus8.alloc_valid), int'(ev));
        chk({tag, ".idx"},   int'(bus8.out_idx),     ei);
        chk({tag, ".free"},  int'(bus8.free_cnt),    ef);
        chk({tag, ".err"},   int'(bus8.err),         int'(ee));
    endtask

    function automatic void m_reset();
        foreach (m_owned[i]) m_owned[i] = 1'b0;
        m_held = -1;
        m_last = 0;
        m_err  = 1'b0;
    endfunction

    function automatic void m_step(bit rst, bit rdy, bit rv, int ri);
        bit pop;
        bit legal;
        int target;
        if (rst) begin
            m_reset();
            return;
        end
        pop    = (m_held >= 0) && rdy;
        legal  = rv && (ri < 8) && m_owned[ri];
        target = -1;
        if (m_held < 0 || pop) begin
            for (int i = 7; i >= 0; i--) begin
                if (!m_owned[i] && i != m_held) target = i;
            end
        end
        if (pop) m_owned[m_held] = 1'b1;
        if (target >= 0) begin
            m_held = target;
            m_last = target;
        end else if (pop) begin
            m_held = -1;
        end
        if (legal) m_owned[ri] = 1'b0;
        if (rv && !legal) m_err = 1'b1;
    endfunction

    function automatic int m_free();
        int n = 8;
        foreach (m_owned[i]) if (m_owned[i]) n--;
        if (m_held >= 0) n--;
        return n;
    endfunction

    function automatic int pick_owned();
        int start = int'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
            if (m_owned[(start + k) % 8]) return (start + k) % 8;
        end
        return start;
    endfunction

    initial begin
        drive8(1'b1, 1'b0, 1'b0, 0);
        rst6              = 1'b1;
        bus6.alloc_ready  = 1'b0;
        bus6.rel_valid    = 1'b0;
        bus6.rel_idx      = '0;

        // Reset then idle
        add("rst", 1, 0, 0, 0, 0, 0, 8, 0);
        add("first", 0, 0, 0, 0, 1, 0, 7, 0);
        for (int k = 0; k < 10; k++) add("idle", 0, 0, 0, 0, 1, 0, 7, 0);
        // Drain all eight, then refill via release of 5
        for (int k = 1; k <= 7; k++) add("drain", 0, 1, 0, 0, 1, k, 7 - k, 0);
        add("drain_end", 0, 1, 0, 0, 0, 7, 0, 0);
        add("empty", 0, 1, 0, 0, 0, 7, 0, 0);
        add("rel5", 0, 0, 1, 5, 0, 7, 1, 0);
        add("refill5", 0, 0, 0, 0, 1, 5, 0, 0);
        // Lowest-first with holes
        add("rst", 1, 0, 0, 0, 0, 0, 8, 0);
        add("first", 0, 0, 0, 0, 1, 0, 7, 0);
        for (int k = 1; k <= 6; k++) add("hand", 0, 1, 0, 0, 1, k, 7 - k, 0);
        add("rel4", 0, 0, 1, 4, 1, 6, 2, 0);
        add("rel1", 0, 0, 1, 1, 1, 6, 3, 0);
        add("pop6", 0, 1, 0, 0, 1, 1, 2, 0);
        add("pop1", 0, 1, 0, 0, 1, 4, 1, 0);
        add("pop4", 0, 1, 0, 0, 1, 7, 0, 0);
        add("pop7", 0, 1, 0, 0, 0, 7, 0, 0);
        // Illegal releases
        add("rst", 1, 0, 0, 0, 0, 0, 8, 0);
        add("first", 0, 0, 0, 0, 1, 0, 7, 0);
        add("ill_unalloc", 0, 0, 1, 3, 1, 0, 7, 1);
        add("ill_held", 0, 0, 1, 0, 1, 0, 7, 1);
        add("pop0", 0, 1, 0, 0, 1, 1, 6, 1);
        add("rel0", 0, 0, 1, 0, 1, 1, 7, 1);
        add("ill_popsame", 0, 1, 1, 1, 1, 0, 6, 1);

        foreach (tbl[n]) begin
            drive8(tbl[n].rst, tbl[n].rdy, tbl[n].rv, tbl[n].ri);
            tick();
            check8(tbl[n].tag, tbl[n].ev, tbl[n].ei, tbl[n].ef, tbl[n].ee);
        end

        // Reset mid-operation: five slots outstanding and err set
        for (int k = 0; k < 4; k++) begin
            drive8(1'b0, 1'b1, 1'b0, 0);
            tick();
        end
        drive8(1'b0, 1'b0, 1'b0, 0);
        tick();
        check8("outstanding", 1'b1, 5, 2, 1'b1);
        drive8(1'b1, 1'b0, 1'b0, 0);
        tick();
        check8("midrst", 1'b0, 0, 8, 1'b0);
        drive8(1'b0, 1'b0, 1'b0, 0);
        tick();
        check8("midrst_refill", 1'b1, 0, 7, 1'b0);

        // ENTRY=6: release of index 6 is out of range
        rst6 = 1'b0;
        tick();
        chk("e6.first.valid", int'(bus6.alloc_valid), 1);
        chk("e6.first.free", int'(bus6.free_cnt), 5);
        bus6.rel_valid = 1'b1;
        bus6.rel_idx   = 3'd6;
        tick();
        chk("e6.ill6.err", int'(bus6.err), 1);
        chk("e6.ill6.free", int'(bus6.free_cnt), 5);
        chk("e6.ill6.idx", int'(bus6.out_idx), 0);
        bus6.rel_valid   = 1'b0;
        bus6.alloc_ready = 1'b1;
        tick();
        chk("e6.pop0.idx", int'(bus6.out_idx), 1);
        chk("e6.pop0.free", int'(bus6.free_cnt), 4);
        chk("e6.pop0.err", int'(bus6.err), 1);
        bus6.alloc_ready = 1'b0;

        // Randomized traffic against the model
        m_reset();
        drive8(1'b1, 1'b0, 1'b0, 0);
        tick();
        check8("rnd_rst", 1'b0, m_last, m_free(), m_err);
        for (int n = 0; n < 800; n++) begin
            bit rst;
            bit rdy;
            bit rv;
            int ri;
            rst = ($urandom_range(0, 149) == 0);
            rdy = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 2) == 0);
            ri  = ($urandom_range(0, 3) != 0) ? pick_owned() : int'($urandom_range(0, 7));
            drive8(rst, rdy, rv, ri);
            m_step(rst, rdy, rv, ri);
            tick();
            check8("rnd", (m_held >= 0), m_last, m_free(), m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
